// File: rtl/gpp_pkg.sv
// Shared parameters and the fetch FSM state type for the instruction-fetch slice.
package gpp_pkg;

    localparam int INSTR_W = 16;
    localparam int ADDR_W  = 9;
    localparam int DEPTH   = 400;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_REQ  = 3'd2,
        ST_WAIT = 3'd3,
        ST_HOLD = 3'd4,
        ST_DONE = 3'd5
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc.sv
// Program-counter register with clear, load and increment controls (clear > load > increment).
module fetch_pc #(
    parameter int ADDR_W = gpp_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] pc
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= '0;
        end else if (clr) begin
            pc <= '0;
        end else if (load) begin
            pc <= target;
        end else if (inc) begin
            pc <= pc + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: optional program load, then request/wait/hold fetch loop with branch redirect.
// The load phase is compiled in only when INSTR_FETCH_LOAD_EN is defined.
module instr_fetch #(
    parameter int DEPTH   = gpp_pkg::DEPTH,
    parameter int ADDR_W  = gpp_pkg::ADDR_W,
    parameter int INSTR_W = gpp_pkg::INSTR_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 fin_file,
    input  logic [INSTR_W-1:0]   return_instr_line,
    output logic                 read_file,
    output logic                 read_memory,
    output logic [ADDR_W-1:0]    pos,
    input  logic                 branch_en,
    input  logic [ADDR_W-1:0]    branch_target,
    input  logic                 instr_ready,
    output logic                 instr_valid,
    output logic [INSTR_W-1:0]   instr_out,
    output logic [ADDR_W-1:0]    instr_pc,
    output logic [ADDR_W:0]      prog_len,
    output logic                 done,
    output gpp_pkg::fetch_state_e state
);

    import gpp_pkg::*;

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_W   = (ADDR_W+1)'(1);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W:0]   pc_plus1;
    logic              pc_clr;
    logic              pc_load;
    logic              pc_inc;
    logic              fetching;
    logic              branch_take;
    logic              target_oob;
    logic              last_word;
    logic              handshake;

    // Handshake: a word transfers on any edge where instr_valid && instr_ready,
    // unless a branch is taken on the same edge, which discards the word.
    assign fetching    = (state == ST_REQ) || (state == ST_WAIT) || (state == ST_HOLD);
    assign branch_take = fetching && branch_en;
    assign handshake   = (state == ST_HOLD) && instr_valid && instr_ready && !branch_en;
    assign pc_plus1    = {1'b0, pc} + ONE_W;
    assign target_oob  = ({1'b0, branch_target} >= prog_len);
    assign last_word   = (pc_plus1 >= prog_len);

    assign pc_clr  = (state == ST_IDLE) && start;
    assign pc_load = branch_take && !target_oob;
    assign pc_inc  = handshake && !last_word;

    assign read_memory = (state == ST_REQ);
    assign pos         = pc;

    fetch_pc #(.ADDR_W(ADDR_W)) u_fetch_pc (
        .clk    (clk),
        .rst    (rst),
        .clr    (pc_clr),
        .load   (pc_load),
        .inc    (pc_inc),
        .target (branch_target),
        .pc     (pc)
    );

`ifdef INSTR_FETCH_LOAD_EN
    logic [ADDR_W:0] count;

    // read_file drops in the same cycle fin_file rises, so no extra line is pulled.
    assign read_file = (state == ST_LOAD) && !fin_file && (count < DEPTH_W);
    assign prog_len  = count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (read_file) begin
            count <= count + ONE_W;
        end
    end
`else
    logic unused_fin_file;

    assign unused_fin_file = fin_file;
    assign read_file       = 1'b0;
    assign prog_len        = DEPTH_W;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            instr_out   <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
`ifdef INSTR_FETCH_LOAD_EN
                        state <= ST_LOAD;
`else
                        state <= ST_REQ;
`endif
                    end
                end
`ifdef INSTR_FETCH_LOAD_EN
                ST_LOAD: begin
                    if (fin_file || (count >= DEPTH_W)) begin
                        if (count == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_REQ;
                        end
                    end
                end
`endif
                ST_REQ, ST_WAIT, ST_HOLD: begin
                    if (branch_en) begin
                        instr_valid <= 1'b0;
                        if (target_oob) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_REQ;
                        end
                    end else if (state == ST_REQ) begin
                        state <= ST_WAIT;
                    end else if (state == ST_WAIT) begin
                        instr_out   <= return_instr_line;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        state       <= ST_HOLD;
                    end else if (handshake) begin
                        instr_valid <= 1'b0;
                        if (last_word) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_REQ;
                        end
                    end
                end
                ST_DONE: begin
                    done <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch; covers the load build when INSTR_FETCH_LOAD_EN is defined.
module tb_instr_fetch;

    import gpp_pkg::*;

    localparam int AW = 9;
    localparam int IW = 16;

`ifdef INSTR_FETCH_LOAD_EN
    localparam int          PLEN  = 5;
    localparam logic [AW-1:0] OOB_T = 9'd7;
    localparam logic [AW:0]   PLEN_RST = 10'd0;
`else
    localparam int          PLEN  = 400;
    localparam logic [AW-1:0] OOB_T = 9'd450;
    localparam logic [AW:0]   PLEN_RST = 10'd400;
`endif

    logic          clk;
    logic          rst;
    logic          start;
    logic          fin_file;
    logic [IW-1:0] return_instr_line;
    logic          read_file;
    logic          read_memory;
    logic [AW-1:0] pos;
    logic          branch_en;
    logic [AW-1:0] branch_target;
    logic          instr_ready;
    logic          instr_valid;
    logic [IW-1:0] instr_out;
    logic [AW-1:0] instr_pc;
    logic [AW:0]   prog_len;
    logic          done;
    fetch_state_e  state;

    logic [IW-1:0] mem [0:399];
    bit            rf_seen;
    int            checks;
    int            errors;

    instr_fetch dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .fin_file          (fin_file),
        .return_instr_line (return_instr_line),
        .read_file         (read_file),
        .read_memory       (read_memory),
        .pos               (pos),
        .branch_en         (branch_en),
        .branch_target     (branch_target),
        .instr_ready       (instr_ready),
        .instr_valid       (instr_valid),
        .instr_out         (instr_out),
        .instr_pc          (instr_pc),
        .prog_len          (prog_len),
        .done              (done),
        .state             (state)
    );

    // clock/reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Registered instruction memory: data valid one edge after read_memory.
    always @(posedge clk) begin
        if (read_memory) return_instr_line <= mem[pos];
        if (read_file) rf_seen <= 1'b1;
    end

    task automatic do_reset();
        start = 0; fin_file = 0; branch_en = 0; branch_target = '0; instr_ready = 1;
        rst = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
    endtask

    // Leaves the caller at the first negedge where the FSM sits in REQ.
    task automatic start_run();
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
`ifdef INSTR_FETCH_LOAD_EN
        for (int i = 0; i < 5; i++) @(negedge clk);
        fin_file = 1;
        @(negedge clk); fin_file = 0;
`endif
    endtask

    task automatic wait_valid(input int budget, output bit ok, output int cycles);
        ok = 0;
        cycles = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            cycles++;
            if (instr_valid) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [50:0] obs, exp;
        do_reset();
        rst = 0;
        #1;
        obs = {read_file, read_memory, pos, instr_valid, instr_out, instr_pc, prog_len, done, state};
        exp = {1'b0, 1'b0, 9'd0, 1'b0, 16'd0, 9'd0, PLEN_RST, 1'b0, ST_IDLE};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL reset_outputs got %h expected %h", obs, exp);
        end
        @(negedge clk); rst = 1;
        @(negedge clk); @(negedge clk);
        checks++;
        if (state !== ST_IDLE) begin
            errors++;
            $display("FAIL idle_without_start got %0d expected %0d", state, ST_IDLE);
        end
    endtask

`ifdef INSTR_FETCH_LOAD_EN
    task automatic test_load();
        do_reset();
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (read_file !== 1'b1 || state !== ST_LOAD) begin
                errors++;
                $display("FAIL load_read_file cycle %0d got rf=%b st=%0d expected rf=1 st=%0d", i, read_file, state, ST_LOAD);
            end
            @(negedge clk);
        end
        fin_file = 1;
        #1;
        checks++;
        if (read_file !== 1'b0 || prog_len !== 10'd5) begin
            errors++;
            $display("FAIL load_fin got rf=%b len=%0d expected rf=0 len=5", read_file, prog_len);
        end
        @(negedge clk); fin_file = 0;
        checks++;
        if (state !== ST_REQ || pos !== 9'd0 || read_memory !== 1'b1 || prog_len !== 10'd5) begin
            errors++;
            $display("FAIL load_first_req got st=%0d pos=%0d rm=%b len=%0d expected st=%0d pos=0 rm=1 len=5",
                     state, pos, read_memory, prog_len, ST_REQ);
        end
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        @(negedge clk);
        #2 rst = 0;
        #1;
        checks++;
        if ({read_file, prog_len, state, read_memory, pos, done} !== {1'b0, 10'd0, ST_IDLE, 1'b0, 9'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_load got rf=%b len=%0d st=%0d expected all zero, IDLE", read_file, prog_len, state);
        end
        @(negedge clk); rst = 1;
    endtask
`else
    task automatic test_no_load();
        do_reset();
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        checks++;
        if (state !== ST_REQ || pos !== 9'd0 || read_memory !== 1'b1) begin
            errors++;
            $display("FAIL noload_direct_req got st=%0d pos=%0d rm=%b expected st=%0d pos=0 rm=1", state, pos, read_memory, ST_REQ);
        end
        checks++;
        if (read_file !== 1'b0 || prog_len !== 10'd400) begin
            errors++;
            $display("FAIL noload_len got rf=%b len=%0d expected rf=0 len=400", read_file, prog_len);
        end
    endtask
`endif

    task automatic test_stream();
        bit ok;
        int cyc;
        logic [IW-1:0] exp_q[$];
        exp_q = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
        do_reset();
        start_run();
        for (int k = 0; k < 5; k++) begin
            wait_valid(20, ok, cyc);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL stream_timeout word %0d got no instr_valid expected valid within 20 cycles", k);
            end
            checks++;
            if (instr_out !== exp_q[k] || instr_pc !== AW'(k)) begin
                errors++;
                $display("FAIL stream_word %0d got %h@%0d expected %h@%0d", k, instr_out, instr_pc, exp_q[k], k);
            end
            if (k > 0) begin
                checks++;
                if (cyc !== 3) begin
                    errors++;
                    $display("FAIL stream_gap word %0d got %0d cycles expected 3", k, cyc);
                end
            end
        end
        @(negedge clk);
        checks++;
        if (done !== (PLEN == 5) || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_done got done=%b valid=%b expected done=%b valid=0", done, instr_valid, PLEN == 5);
        end
    endtask

    task automatic test_stall();
        bit ok;
        int cyc;
        do_reset();
        start_run();
        for (int k = 0; k < 3; k++) wait_valid(20, ok, cyc);
        instr_ready = 0;
        checks++;
        if (!ok || instr_pc !== 9'd2) begin
            errors++;
            $display("FAIL stall_entry got ok=%b pc=%0d expected ok=1 pc=2", ok, instr_pc);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (instr_out !== 16'h3333 || instr_valid !== 1'b1 || read_memory !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold cycle %0d got out=%h v=%b rm=%b expected out=3333 v=1 rm=0",
                         i, instr_out, instr_valid, read_memory);
            end
        end
        instr_ready = 1;
        @(negedge clk);
        checks++;
        if (state !== ST_REQ || pos !== 9'd3 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_release got st=%0d pos=%0d v=%b expected st=%0d pos=3 v=0", state, pos, instr_valid, ST_REQ);
        end
        wait_valid(20, ok, cyc);
        checks++;
        if (!ok || instr_out !== 16'h4444 || instr_pc !== 9'd3) begin
            errors++;
            $display("FAIL stall_next got ok=%b %h@%0d expected 4444@3", ok, instr_out, instr_pc);
        end
    endtask

    task automatic test_branch();
        bit ok;
        int cyc;
        do_reset();
        start_run();
        for (int k = 0; k < 4; k++) wait_valid(20, ok, cyc);
        checks++;
        if (!ok || instr_pc !== 9'd3) begin
            errors++;
            $display("FAIL branch_entry got ok=%b pc=%0d expected ok=1 pc=3", ok, instr_pc);
        end
        branch_en = 1;
        branch_target = 9'd1;
        @(negedge clk);
        branch_en = 0;
        checks++;
        if (instr_valid !== 1'b0 || state !== ST_REQ || pos !== 9'd1 || read_memory !== 1'b1) begin
            errors++;
            $display("FAIL branch_redirect got v=%b st=%0d pos=%0d rm=%b expected v=0 st=%0d pos=1 rm=1",
                     instr_valid, state, pos, read_memory, ST_REQ);
        end
        wait_valid(20, ok, cyc);
        checks++;
        if (!ok || instr_out !== 16'h2222 || instr_pc !== 9'd1) begin
            errors++;
            $display("FAIL branch_next got ok=%b %h@%0d expected 2222@1", ok, instr_out, instr_pc);
        end
        for (int k = 0; k < 2; k++) wait_valid(20, ok, cyc);
        checks++;
        if (!ok || instr_out !== 16'h4444 || instr_pc !== 9'd3) begin
            errors++;
            $display("FAIL branch_refetch got ok=%b %h@%0d expected 4444@3", ok, instr_out, instr_pc);
        end
    endtask

    task automatic test_branch_oob();
        bit ok;
        int cyc;
        do_reset();
        start_run();
        wait_valid(20, ok, cyc);
        branch_en = 1;
        branch_target = OOB_T;
        @(negedge clk);
        branch_en = 0;
        checks++;
        if (done !== 1'b1 || state !== ST_DONE || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL branch_oob got done=%b st=%0d v=%b expected done=1 st=%0d v=0", done, state, instr_valid, ST_DONE);
        end
        start = 1;
        branch_en = 1;
        branch_target = 9'd0;
        @(negedge clk);
        start = 0;
        branch_en = 0;
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || state !== ST_DONE || read_memory !== 1'b0) begin
            errors++;
            $display("FAIL done_sticky got done=%b st=%0d rm=%b expected done=1 st=%0d rm=0", done, state, read_memory, ST_DONE);
        end
    endtask

    task automatic test_reset_mid_hold();
        bit ok;
        int cyc;
        do_reset();
        start_run();
        wait_valid(20, ok, cyc);
        #2 rst = 0;
        #1;
        checks++;
        if ({instr_valid, instr_out, instr_pc, state, read_memory, pos, done} !==
            {1'b0, 16'd0, 9'd0, ST_IDLE, 1'b0, 9'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_hold got v=%b out=%h pc=%0d st=%0d expected zeros, IDLE", instr_valid, instr_out, instr_pc, state);
        end
        @(negedge clk); rst = 1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rf_seen = 0;
        return_instr_line = '0;
        for (int i = 0; i < 400; i++) mem[i] = (i < 5) ? 16'(16'h1111 * (i + 1)) : 16'(16'hA000 | i);

        test_reset();
`ifdef INSTR_FETCH_LOAD_EN
        test_load();
        test_reset_mid_load();
`else
        test_no_load();
`endif
        test_stream();
        test_stall();
        test_branch();
        test_branch_oob();
        test_reset_mid_hold();
`ifndef INSTR_FETCH_LOAD_EN
        checks++;
        if (rf_seen !== 1'b0) begin
            errors++;
            $display("FAIL noload_read_file got asserted expected never");
        end
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
